hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall controller.
- Drives the enable and synchronous-clear inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards and taken-branch flushes, and sequences the multi-cycle stall needed by mult/div in EX.
- Keeps saturating performance counters for stall cycles and flush events.

---
 rtl/hazard_stall_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch flushes,
// multi-cycle mult/div stall sequencing and saturating perf counters.
module hazard_stall_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_BITS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_mem_read,
  input  logic [4:0]          ex_rt,
  input  logic                ex_branch_taken,
  input  logic                ex_md_start,
  input  logic                perf_clear,
  output logic                pc_enable,
  output logic                ifid_enable,
  output logic                ifid_flush,
  output logic                idex_enable,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic                md_busy,
  output logic [CNT_BITS-1:0] stall_cycles,
  output logic [CNT_BITS-1:0] flush_events
);

  localparam int MD_CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [CNT_BITS-1:0] r_stall_cnt;
  logic [CNT_BITS-1:0] r_flush_cnt;

  logic w_run;
  logic w_md_stall;
  logic w_branch;
  logic w_load_use;
  logic w_hazard_match;

  assign w_run          = (r_state == RUN);
  assign w_hazard_match = (id_uses_rs && (id_rs == ex_rt)) ||
                          (id_uses_rt && (id_rt == ex_rt));

  // Priority: mult/div stall, then taken branch, then load-use.
  assign w_md_stall = (w_run && ex_md_start) ||
                      (!w_run && (r_md_cnt != '0));
  assign w_branch   = w_run && !ex_md_start && ex_branch_taken;
  assign w_load_use = w_run && !ex_md_start && !ex_branch_taken &&
                      ex_mem_read && (ex_rt != 5'd0) && w_hazard_match;

  assign pc_enable   = !rst && !w_md_stall && !w_load_use;
  assign ifid_enable = !rst && !w_md_stall && !w_load_use;
  assign idex_enable = !rst && !w_md_stall;
  assign ifid_flush  = !rst && w_branch;
  assign idex_flush  = !rst && (w_branch || w_load_use);
  assign exmem_flush = !rst && w_md_stall;
  assign md_busy     = !rst && !w_run;

  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_md_start) begin
            r_state  <= MD_WAIT;
            r_md_cnt <= MD_CNT_W'(MD_CYCLES - 2);
          end
        end
        MD_WAIT: begin
          // ex_md_start stays high from the held instruction, so it is ignored here.
          if (r_md_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          r_state  <= RUN;
          r_md_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perf_clear) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_enable && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
      end
      if (ifid_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances share stimulus
// (MD_CYCLES=4, MD_CYCLES=2, and a 4-bit counter variant for saturation).
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       ex_md_start;
  logic       perf_clear;

  logic        a_pc_en, a_ifid_en, a_ifid_fl, a_idex_en, a_idex_fl, a_exmem_fl, a_busy;
  logic [31:0] a_stall, a_flush;
  logic        b_pc_en, b_ifid_en, b_ifid_fl, b_idex_en, b_idex_fl, b_exmem_fl, b_busy;
  logic [31:0] b_stall, b_flush;
  logic        s_pc_en, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_fl, s_exmem_fl, s_busy;
  logic [3:0]  s_stall, s_flush;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_BITS(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .perf_clear(perf_clear),
    .pc_enable(a_pc_en), .ifid_enable(a_ifid_en), .ifid_flush(a_ifid_fl),
    .idex_enable(a_idex_en), .idex_flush(a_idex_fl), .exmem_flush(a_exmem_fl),
    .md_busy(a_busy), .stall_cycles(a_stall), .flush_events(a_flush)
  );

  hazard_stall_ctrl #(.MD_CYCLES(2), .CNT_BITS(32)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .perf_clear(perf_clear),
    .pc_enable(b_pc_en), .ifid_enable(b_ifid_en), .ifid_flush(b_ifid_fl),
    .idex_enable(b_idex_en), .idex_flush(b_idex_fl), .exmem_flush(b_exmem_fl),
    .md_busy(b_busy), .stall_cycles(b_stall), .flush_events(b_flush)
  );

  hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_BITS(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .perf_clear(perf_clear),
    .pc_enable(s_pc_en), .ifid_enable(s_ifid_en), .ifid_flush(s_ifid_fl),
    .idex_enable(s_idex_en), .idex_flush(s_idex_fl), .exmem_flush(s_exmem_fl),
    .md_busy(s_busy), .stall_cycles(s_stall), .flush_events(s_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    ex_md_start = 1'b0; perf_clear = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_rt = r; id_rs = r; id_uses_rs = 1'b1;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_pc_en", a_pc_en, 0);
    chk("rst_ifid_en", a_ifid_en, 0);
    chk("rst_idex_en", a_idex_en, 0);
    chk("rst_flushes", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_stall_cnt", a_stall, 0);
    chk("rst_flush_cnt", a_flush, 0);
    tick();
    #3 rst = 1'b0;
    tick();
    chk("idle_enables", {a_pc_en, a_ifid_en, a_idex_en}, 3'b111);
    chk("idle_flushes", {a_ifid_fl, a_idex_fl, a_exmem_fl}, 0);

    // Load-use on rs
    load_use(5'd8);
    #2;
    chk("lu_pc_en", a_pc_en, 0);
    chk("lu_ifid_en", a_ifid_en, 0);
    chk("lu_idex_fl", a_idex_fl, 1);
    chk("lu_idex_en", a_idex_en, 1);
    chk("lu_ifid_fl", a_ifid_fl, 0);
    tick();
    idle();
    #1;
    chk("lu_released_pc_en", a_pc_en, 1);
    chk("lu_stall_cnt", a_stall, 1);

    // Load targeting $zero never stalls
    load_use(5'd0);
    #1;
    chk("lu_r0_pc_en", a_pc_en, 1);
    chk("lu_r0_idex_fl", a_idex_fl, 0);
    tick();
    chk("lu_r0_stall_cnt", a_stall, 1);

    // Load-use via rt only
    idle();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd5;
    #1;
    chk("lu_rt_pc_en", a_pc_en, 0);
    id_uses_rt = 1'b0;
    #1;
    chk("lu_unused_pc_en", a_pc_en, 1);

    // Taken branch with simultaneous load-use: flush wins
    idle();
    load_use(5'd9);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_ifid_fl", a_ifid_fl, 1);
    chk("br_idex_fl", a_idex_fl, 1);
    chk("br_pc_en", a_pc_en, 1);
    chk("br_exmem_fl", a_exmem_fl, 0);
    tick();
    idle();
    #1;
    chk("br_flush_cnt", a_flush, 1);
    chk("br_stall_cnt", a_stall, 1);

    // Mult/div held in EX; branch+md together: md wins
    ex_md_start = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    chk("md_c1_pc_en", a_pc_en, 0);
    chk("md_c1_idex_en", a_idex_en, 0);
    chk("md_c1_exmem_fl", a_exmem_fl, 1);
    chk("md_c1_ifid_fl", a_ifid_fl, 0);
    chk("md_c1_busy", a_busy, 0);
    chk("md2_c1_pc_en", b_pc_en, 0);
    ex_branch_taken = 1'b0;
    tick();
    chk("md_c2_busy", a_busy, 1);
    chk("md_c2_pc_en", a_pc_en, 0);
    chk("md2_c2_release", b_pc_en, 1);
    chk("md2_c2_busy", b_busy, 1);
    tick();
    chk("md_c3_pc_en", a_pc_en, 0);
    chk("md_c3_exmem_fl", a_exmem_fl, 1);
    tick();
    ex_branch_taken = 1'b1;
    load_use(5'd3);
    #1;
    chk("md_c4_pc_en", a_pc_en, 1);
    chk("md_c4_exmem_fl", a_exmem_fl, 0);
    chk("md_c4_busy", a_busy, 1);
    chk("md_c4_br_ignored", a_ifid_fl, 0);
    chk("md_c4_lu_ignored", a_idex_fl, 0);
    tick();
    idle();
    #1;
    chk("md_done_busy", a_busy, 0);
    chk("md_stall_cnt", a_stall, 4);
    chk("md2_stall_cnt", b_stall, 3);
    chk("md_flush_cnt", a_flush, 1);

    // Async reset in the middle of MD_WAIT
    ex_md_start = 1'b1;
    tick();
    chk("mdr_busy_before", a_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mdr_busy_in_rst", a_busy, 0);
    chk("mdr_pc_en_in_rst", a_pc_en, 0);
    chk("mdr_stall_cnt_rst", a_stall, 0);
    idle();
    #2 rst = 1'b0;
    tick();
    chk("mdr_after_pc_en", a_pc_en, 1);
    chk("mdr_after_busy", a_busy, 0);
    chk("mdr_after_stall_cnt", a_stall, 0);
    ex_md_start = 1'b1;
    #1;
    chk("mdr_restart_c1", a_pc_en, 0);
    tick();
    chk("mdr_restart_c2", {a_busy, a_pc_en}, 2'b10);
    tick();
    chk("mdr_restart_c3", a_pc_en, 0);
    tick();
    chk("mdr_restart_c4", a_pc_en, 1);
    tick();
    idle();
    #1;
    chk("mdr_stall_cnt", a_stall, 3);

    // Saturation of the 4-bit counter over 20 load-use cycles
    load_use(5'd12);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt4", s_stall, 15);
    chk("sat_stall_cnt32", a_stall, 23);
    perf_clear = 1'b1;
    tick();
    chk("clr_stall_cnt4", s_stall, 0);
    chk("clr_stall_cnt32", a_stall, 0);
    chk("clr_flush_cnt4", s_flush, 0);
    perf_clear = 1'b0;
    tick();
    chk("post_clr_stall_cnt4", s_stall, 1);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
